dp23_write_arbiter: RTL and testbench

Shares the DP23 FIFO write port between `NumPorts` packet sources on the FIFO write clock, granting one whole packet at a time in round-robin order. Each granted packet is framed with a header word (source ID, per-port sequence number) and a trailer word (data word count, overlength flag). Writes never occur while the FIFO is full, and new packets start only when the FIFO is not almost full. It sits directly in front of the DP23 FIFO write side and replaces direct single-source writes.

---
 rtl/dp23_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/dp23_write_arbiter.sv | 133 +++++++++++++
 tb/tb_dp23_write_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp23_arb_pkg.sv
// Shared types and framing constants for the DP23 FIFO write-port arbiter.
// Header and trailer layouts are fixed at 32 bits.
package dp23_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_TRAILER
    } state_e;

    localparam logic [7:0] HDR_MARKER = 8'hAB;
    localparam logic [7:0] TRL_MARKER = 8'hCD;
    localparam int         SEQ_WIDTH  = 16;
    localparam int         CNT_WIDTH  = 17;

    localparam logic [CNT_WIDTH-1:0] CNT_SAT = 17'h10000;

    // An overlength packet reports 0xFFFF with the overflow flag set.
    function automatic logic [31:0] trailer_word(input logic [CNT_WIDTH-1:0] cnt);
        logic ovl;
        ovl = cnt[CNT_WIDTH-1];
        return {TRL_MARKER, 7'b0, ovl, (ovl ? 16'hFFFF : cnt[15:0])};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester search starting one past the last granted port.
// The pointer advances only when the owner's packet is finished.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N-1:0]                 req_i,
    input  logic                         update_i,
    input  logic [$clog2(N)-1:0]         update_idx_i,
    output logic [N-1:0]                 grant_o,
    output logic [$clog2(N)-1:0]         grant_idx_o,
    output logic                         any_o
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= IW'(N - 1);
        end else if (update_i) begin
            ptr_q <= update_idx_i;
        end
    end

    // NOTE: every output gets a default before the search so no path leaves
    // a value held, which would infer a latch.
    always_comb begin
        logic [IW-1:0] idx;
        idx         = '0;
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr_q) + k) % N);
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/dp23_write_arbiter.sv
// Shares the DP23 FIFO write port between packet sources, one framed packet
// (header, data, trailer) at a time in round-robin order.
module dp23_write_arbiter
    import dp23_arb_pkg::*;
#(
    parameter int NumPorts  = 4,
    parameter int GpifWidth = 32
) (
    input  logic                          clk_dp_wr_i,
    input  logic                          dpo_rst_wrclk_i,
    input  logic                          en_i,
    input  logic [NumPorts-1:0]           s_valid_i,
    input  logic [NumPorts-1:0]           s_last_i,
    input  logic [NumPorts*GpifWidth-1:0] s_data_i,
    output logic [NumPorts-1:0]           s_ready_o,
    input  logic                          dpo_full_i,
    input  logic                          dpo_almost_full_i,
    output logic                          dpo_wr_o,
    output logic [GpifWidth-1:0]          dpo_dti_o,
    output logic [NumPorts-1:0]           grant_o,
    output logic                          busy_o,
    output logic [31:0]                   pkt_count_o
);
    localparam int IW = $clog2(NumPorts);

    state_e                state_q, state_d;
    logic [NumPorts-1:0]   grant_q;
    logic [IW-1:0]         port_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [SEQ_WIDTH-1:0]  seq_q [NumPorts];
    logic [31:0]           pkt_q;
    logic                  busy_q;

    logic [NumPorts-1:0]   arb_grant;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;
    logic                  start, cur_valid, cur_last, beat, trl_wr;
    logic [GpifWidth-1:0]  cur_data;

    // Almost-full gates only the start of a packet; an active one runs on.
    assign start     = en_i && !dpo_almost_full_i && arb_any;
    assign cur_valid = s_valid_i[port_q];
    assign cur_last  = s_last_i[port_q];
    assign cur_data  = s_data_i[port_q*GpifWidth +: GpifWidth];
    assign beat      = (state_q == ST_DATA) && cur_valid && !dpo_full_i;
    assign trl_wr    = (state_q == ST_TRAILER) && !dpo_full_i;

    rr_arbiter #(.N(NumPorts)) u_rr (
        .clk_i        (clk_dp_wr_i),
        .rst_i        (dpo_rst_wrclk_i),
        .req_i        (s_valid_i),
        .update_i     (trl_wr),
        .update_idx_i (port_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .any_o        (arb_any)
    );

    always_ff @(posedge clk_dp_wr_i) begin
        if (dpo_rst_wrclk_i) state_q <= ST_IDLE;
        else                 state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start)           state_d = ST_HEADER;
            ST_HEADER:  if (!dpo_full_i)     state_d = ST_DATA;
            ST_DATA:    if (beat && cur_last) state_d = ST_TRAILER;
            ST_TRAILER: if (!dpo_full_i)     state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // Write strobe, data and ready all depend on the current full flag.
    always_comb begin
        s_ready_o = '0;
        dpo_wr_o  = 1'b0;
        dpo_dti_o = '0;
        unique case (state_q)
            ST_HEADER: if (!dpo_full_i) begin
                dpo_wr_o  = 1'b1;
                dpo_dti_o = {HDR_MARKER, 8'(port_q), seq_q[port_q]};
            end
            ST_DATA: begin
                s_ready_o[port_q] = !dpo_full_i;
                if (beat) begin
                    dpo_wr_o  = 1'b1;
                    dpo_dti_o = cur_data;
                end
            end
            ST_TRAILER: if (!dpo_full_i) begin
                dpo_wr_o  = 1'b1;
                dpo_dti_o = trailer_word(cnt_q);
            end
            default: ;
        endcase
    end

    // NOTE: the sequence-number array is reset explicitly; sequence numbers
    // restart at zero after any reset, so it cannot be left to power-up state.
    always_ff @(posedge clk_dp_wr_i) begin
        if (dpo_rst_wrclk_i) begin
            grant_q <= '0;
            port_q  <= '0;
            cnt_q   <= '0;
            pkt_q   <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NumPorts; i++) seq_q[i] <= '0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            unique case (state_q)
                ST_IDLE: if (start) begin
                    grant_q <= arb_grant;
                    port_q  <= arb_idx;
                    cnt_q   <= '0;
                end
                ST_DATA: if (beat && cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
                ST_TRAILER: if (trl_wr) begin
                    seq_q[port_q] <= seq_q[port_q] + 1'b1;
                    pkt_q         <= pkt_q + 1'b1;
                    grant_q       <= '0;
                end
                default: ;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign pkt_count_o = pkt_q;

endmodule

// File: tb/tb_dp23_write_arbiter.sv
// Bench for dp23_write_arbiter: per-port packet queues feed the DUT and a
// transaction-level model predicts the exact FIFO word stream.
module tb_dp23_write_arbiter;
    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              rst, en, full, af, wr, busy;
    logic [NP-1:0]     s_valid, s_last, s_ready, grant;
    logic [NP*32-1:0]  s_data;
    logic [31:0]       dti, pkt_cnt;

    always #5 clk = ~clk;

    dp23_write_arbiter #(.NumPorts(NP), .GpifWidth(32)) dut (
        .clk_dp_wr_i       (clk),
        .dpo_rst_wrclk_i   (rst),
        .en_i              (en),
        .s_valid_i         (s_valid),
        .s_last_i          (s_last),
        .s_data_i          (s_data),
        .s_ready_o         (s_ready),
        .dpo_full_i        (full),
        .dpo_almost_full_i (af),
        .dpo_wr_o          (wr),
        .dpo_dti_o         (dti),
        .grant_o           (grant),
        .busy_o            (busy),
        .pkt_count_o       (pkt_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Source queues: one entry per data word, with its last flag.
    logic [31:0] src_d [NP][$];
    bit          src_l [NP][$];

    // Reference model state.
    logic [31:0] exp_q [$];
    int          seq_m [NP];
    int          last_port, cur_port, words_left, model_pkts;
    bit          in_pkt, hdr_done;

    bit          chk_en, rand_mode;
    int          cyc, full_lo, full_hi, stall_cnt;
    logic [31:0] wr_log [$];
    int          wr_cyc [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        in_pkt = 0; hdr_done = 0; words_left = 0; model_pkts = 0;
        last_port = NP - 1;
        for (int p = 0; p < NP; p++) begin
            seq_m[p] = 0;
            src_d[p].delete();
            src_l[p].delete();
        end
    endtask

    function automatic int pick_port();
        for (int k = 1; k <= NP; k++)
            if (src_d[(last_port + k) % NP].size() > 0) return (last_port + k) % NP;
        return -1;
    endfunction

    // Expected frame for the packet at the front of port p's queue.
    task automatic start_packet(input int p);
        int len = 0;
        while (len < src_l[p].size() && !src_l[p][len]) len++;
        len++;
        exp_q.push_back({8'hAB, 8'(p), 16'(seq_m[p])});
        for (int i = 0; i < len; i++) exp_q.push_back(src_d[p][i]);
        if (len >= 65536) exp_q.push_back(32'hCD01FFFF);
        else              exp_q.push_back({16'hCD00, 16'(len)});
        cur_port = p; words_left = len; in_pkt = 1; hdr_done = 0;
    endtask

    function automatic int pending();
        int n = exp_q.size() + int'(in_pkt);
        for (int p = 0; p < NP; p++) n += src_d[p].size();
        return n;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (i < wr_log.size()) ? wr_log[i] : 32'hDEADBEEF;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
    endfunction

    task automatic push_word(input int p, input logic [31:0] d, input bit last);
        src_d[p].push_back(d);
        src_l[p].push_back(last);
    endtask

    task automatic push_pkt(input int p, input int len, input logic [31:0] base);
        for (int i = 0; i < len; i++) push_word(p, base + 32'(i), i == len - 1);
    endtask

    // One clock: drive at edge+1, check at negedge, pop accepted word after the edge.
    task automatic cycle();
        int acc = -1;
        int pp;
        logic [NP-1:0] oh;
        for (int p = 0; p < NP; p++) begin
            s_valid[p]          = src_d[p].size() > 0;
            s_data[p*32 +: 32]  = s_valid[p] ? src_d[p][0] : $urandom;
            s_last[p]           = s_valid[p] ? src_l[p][0] : 1'($urandom);
        end
        if (rand_mode) begin
            full = ($urandom_range(0, 4) == 0);
            af   = ($urandom_range(0, 3) == 0);
            en   = ($urandom_range(0, 7) != 0);
        end else begin
            full = (cyc >= full_lo && cyc < full_hi);
        end
        @(negedge clk);
        if (chk_en) begin
            oh = in_pkt ? (NP'(1) << cur_port) : '0;
            check("pkt_count", pkt_cnt, model_pkts);
            if (in_pkt) begin
                check("grant", grant, oh);
                check("busy", busy, 1);
            end
            if (in_pkt && hdr_done && words_left > 0) begin
                check("ready", s_ready, full ? '0 : oh);
                check("data_wr", wr, !full);
                if (!wr) stall_cnt++;
            end else begin
                check("ready_off", s_ready, 0);
                if (in_pkt && hdr_done) check("trailer_wr", wr, !full);
            end
            if (full) check("wr_while_full", wr, 0);
            if (!wr) begin
                check("dti_zero", dti, 0);
            end else begin
                wr_log.push_back(dti);
                wr_cyc.push_back(cyc);
                if (!in_pkt) begin
                    pp = pick_port();
                    if (pp < 0) check("spurious_write", wr, 0);
                    else begin
                        start_packet(pp);
                        check("grant_at_header", grant, NP'(1) << pp);
                    end
                end
                if (exp_q.size() > 0) check("word", dti, exp_q.pop_front());
                if (in_pkt) begin
                    if (!hdr_done)           hdr_done = 1;
                    else if (words_left > 0) words_left--;
                    else begin
                        in_pkt = 0;
                        model_pkts++;
                        seq_m[cur_port] = (seq_m[cur_port] + 1) % 65536;
                        last_port = cur_port;
                    end
                end
            end
        end
        for (int p = 0; p < NP; p++) if (s_ready[p] && s_valid[p]) acc = p;
        @(posedge clk);
        #1;
        cyc++;
        if (acc >= 0) begin
            void'(src_d[acc].pop_front());
            void'(src_l[acc].pop_front());
        end
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while (pending() > 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain", pending(), 0);
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        chk_en = 0;
        for (int p = 0; p < NP; p++) begin
            src_d[p].delete();
            src_l[p].delete();
        end
        rst = 1;
        cycle();
        rst = 0;
        model_reset();
        chk_en = 1;
    endtask

    task automatic clear_log();
        wr_log.delete();
        wr_cyc.delete();
    endtask

    initial begin
        int c0;
        logic [31:0] w;
        logic [31:0] hdrs [$];

        rst = 1; en = 1; full = 0; af = 0;
        s_valid = '0; s_last = '0; s_data = '0;
        chk_en = 0; rand_mode = 0; full_lo = -1; full_hi = -1; cyc = 0; stall_cnt = 0;
        model_reset();
        repeat (2) cycle();
        rst = 0;
        model_reset();
        chk_en = 1;

        // Reset state
        cycle();
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_pkt", pkt_cnt, 0);
        check("rst_wr", wr, 0);

        // Single 3-word packet from port 0, minimum latency
        clear_log();
        push_word(0, 32'h11, 0); push_word(0, 32'h22, 0); push_word(0, 32'h33, 1);
        c0 = cyc;
        run_idle(50);
        check("t2_words", wr_log.size(), 5);
        check("t2_hdr", log_at(0), 32'hAB000000);
        check("t2_d0", log_at(1), 32'h11);
        check("t2_d2", log_at(3), 32'h33);
        check("t2_trl", log_at(4), 32'hCD000003);
        check("t2_hdr_cyc", cyc_at(0), c0 + 1);
        check("t2_trl_cyc", cyc_at(4), c0 + 5);
        check("t2_pkt", pkt_cnt, 1);

        // All ports continuously valid with 2-word packets
        do_reset();
        clear_log();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) push_pkt(p, 2, 32'(p * 16 + r * 4));
        run_idle(200);
        hdrs.delete();
        foreach (wr_log[i]) if (wr_log[i][31:24] == 8'hAB) hdrs.push_back(wr_log[i]);
        check("t3_hdrs", hdrs.size(), 8);
        for (int k = 0; k < 5 && k < hdrs.size(); k++) begin
            w = hdrs[k];
            check("t3_order", w[23:16], k % NP);
        end
        if (hdrs.size() > 4) check("t3_hdr5", hdrs[4], 32'hAB000001);
        check("t3_pkt", pkt_cnt, 8);

        // Full for 5 cycles in mid-DATA
        clear_log();
        stall_cnt = 0;
        push_pkt(1, 6, 32'h100);
        c0 = cyc;
        full_lo = c0 + 4;
        full_hi = c0 + 9;
        run_idle(100);
        full_lo = -1; full_hi = -1;
        check("t4_stalls", stall_cnt, 5);
        check("t4_words", wr_log.size(), 8);
        check("t4_trl_cyc", cyc_at(7), c0 + 13);

        // Almost-full blocks a new grant; release starts the header a cycle later
        clear_log();
        af = 1;
        push_pkt(2, 2, 32'h200);
        repeat (4) begin
            cycle();
            check("t5_busy", busy, 0);
            check("t5_grant", grant, 0);
        end
        af = 0;
        c0 = cyc;
        run_idle(50);
        check("t5_hdr_cyc", cyc_at(0), c0 + 1);
        w = log_at(0);
        check("t5_port", w[23:16], 2);

        // Reset in mid-DATA, then a 1-word packet from port 1
        push_pkt(0, 10, 32'h300);
        repeat (4) cycle();
        do_reset();
        cycle();
        check("t6_busy", busy, 0);
        check("t6_pkt0", pkt_cnt, 0);
        clear_log();
        push_word(1, 32'h5A5A, 1);
        run_idle(50);
        check("t6_hdr", log_at(0), 32'hAB010000);
        check("t6_data", log_at(1), 32'h5A5A);
        check("t6_trl", log_at(2), 32'hCD000001);
        check("t6_pkt", pkt_cnt, 1);

        // Randomized packets, backpressure, almost-full and enable
        do_reset();
        for (int n = 0; n < 40; n++) begin
            int p = $urandom_range(0, NP - 1);
            int len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) push_word(p, $urandom, i == len - 1);
        end
        rand_mode = 1;
        run_idle(4000);
        rand_mode = 0;
        en = 1; af = 0; full = 0;
        check("t7_pkt", pkt_cnt, 40);

        // Overlength packet saturates the count
        clear_log();
        push_pkt(3, 65537, 32'h0);
        run_idle(70000);
        check("t8_words", wr_log.size(), 65539);
        check("t8_trl", log_at(65538), 32'hCD01FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
